// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer scheduler: FSM states, default grant width and
// the load value that bypasses the Timer.
package timer_sched_pkg;

    typedef enum logic [2:0] {IDLE, START, ARM, RUN, DONE} state_t;

    localparam int ID_W_DEF = 2;
    localparam int ZERO_VAL = 0;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin picker: searches from ptr+1 upward with wrap, so ptr itself is
// considered last. Returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_vld
);

    logic [N_REQ-1:0] oh;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        oh      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            oh = N_REQ'(1) << ((int'(ptr) + k) % N_REQ);
            if (!gnt_vld && (req_vec & oh) != '0) begin
                gnt_vld = 1'b1;
                gnt     = oh;
                gnt_idx = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one countdown Timer among N_REQ requesters, round-robin.
// Optional macro TIMER_PREEMPT_EN: pending requester 0 aborts any other owner's run.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int VAL_W = 4,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       cancel,
    input  logic [N_REQ*VAL_W-1:0] req_value,
    input  logic                   expired,
    output logic [VAL_W-1:0]       timer_value,
    output logic                   start_timer,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [N_REQ-1:0]       pending,
    output logic [N_REQ-1:0]       done
);

    state_t                        state_q, state_d;
    logic [N_REQ-1:0][VAL_W-1:0]   val_q;
    logic [N_REQ-1:0]              owner_oh, pend_d, elig, arb_req, arb_gnt;
    logic [ID_W-1:0]               ptr_q, arb_idx;
    logic [VAL_W-1:0]              win_val;
    logic                          arb_vld, grant, abort, cancel_own, preempt;

    assign elig       = pending & ~cancel;
    assign cancel_own = (cancel & owner_oh) != '0;

`ifdef TIMER_PREEMPT_EN
    // Index 0 jumps the round-robin queue and evicts any other owner.
    assign preempt = pending[0] && !cancel[0] && !owner_oh[0];
    assign arb_req = elig[0] ? N_REQ'(1) : elig;
`else
    assign preempt = 1'b0;
    assign arb_req = elig;
`endif

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_vec (arb_req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        win_val = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_gnt[i]) win_val = val_q[i];
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (arb_vld) begin
                grant   = 1'b1;
                state_d = (win_val == VAL_W'(ZERO_VAL)) ? DONE : START;
            end
            START, ARM, RUN: begin
                if (cancel_own || preempt) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (state_q == START) state_d = ARM;
                else if (state_q == ARM)       state_d = RUN;   // stale expired ignored here
                else if (expired)              state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Aborted owner is re-queued; a same-cycle cancel then clears it again.
    always_comb begin
        pend_d = pending;
        if (grant) pend_d = pend_d & ~arb_gnt;
        if (abort) pend_d = pend_d | owner_oh;
        pend_d = (pend_d | req) & ~cancel;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pending     <= '0;
            val_q       <= '0;
            owner_oh    <= '0;
            grant_id    <= '0;
            ptr_q       <= '0;
            timer_value <= '0;
        end else begin
            state_q <= state_d;
            pending <= pend_d;
            for (int i = 0; i < N_REQ; i++)
                if (req[i]) val_q[i] <= req_value[i*VAL_W +: VAL_W];
            if (grant) begin
                grant_id    <= arb_idx;
                owner_oh    <= arb_gnt;
                timer_value <= win_val;
            end
            if (state_q == DONE) ptr_q <= grant_id;
        end
    end

    assign start_timer = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE) ? owner_oh : '0;

endmodule
